femto_bus_fabric: RTL and testbench
===================================

// Module: femto_bus_fabric
// PURPOSE
//  Parametrised memory-mapped interconnect between the FemtoRV32 core and N peripheral slots.
//  Decodes mem_addr[31:16] into one-hot slot selects and gates rd/wr strobes to the selected slot.
//  Latches the target slot per transaction and muxes its read data back to the core.
//  Aggregates per-slot busy flags; an optional watchdog aborts transactions that hang.
// PARAMETERS
//  N_SLOTS        8          number of slave slots (2..16); slot 0 = program memory / default
//  SLOT_BASE      16'h0040   mem_addr[31:16] value of slot 1; slot k at SLOT_BASE+k-1
//  DEFAULT_SLOT   0          slot selected when the decode misses
//  TIMEOUT_CYCLES 1024       watchdog limit, cycles of continuous busy (BUS_TIMEOUT_EN only)
//  ERR_RDATA      32'hDEAD_BEEF  read data returned on timeout abort
// PORTS
//  clk         in   1         system clock
//  rst_n       in   1         asynchronous active-low reset
//  mem_addr    in   32        core byte address
//  mem_rstrb   in   1         core read strobe (1-cycle pulse)
//  mem_wmask   in   4         core byte write mask; write when nonzero
//  mem_rdata   out  32        read data to core
//  mem_rbusy   out  1         read busy to core
//  mem_wbusy   out  1         write busy to core
//  slv_sel     out  N_SLOTS   one-hot combinational decode of mem_addr
//  slv_rd      out  N_SLOTS   per-slot read strobe
//  slv_wr      out  N_SLOTS   per-slot write strobe
//  slv_rdata   in   32*N_SLOTS  flattened slot read data, slot k at [32k+31:32k]
//  slv_rbusy   in   N_SLOTS   per-slot read busy
//  slv_wbusy   in   N_SLOTS   per-slot write busy
//  err_clr     in   1         clears sticky error
//  bus_err     out  1         sticky timeout flag
//  err_addr    out  32        mem_addr of the aborted transaction
// BEHAVIOUR
//  Single clock domain (clk), async active-low reset rst_n.
//  Decode: [31:16]==16'h0000 -> slot 0; SLOT_BASE..SLOT_BASE+N_SLOTS-2 -> slots 1..N-1; else DEFAULT_SLOT.
//  slv_rd = mem_rstrb & slv_sel (zero latency); slv_wr = |mem_wmask & slv_sel (zero latency).
//  rstrb and nonzero wmask in same cycle: write wins, slv_rd all zero.
//  FSM IDLE/RD_WAIT/WR_WAIT. IDLE + rstrb -> RD_WAIT, latch slot index + addr;
//   IDLE + write -> WR_WAIT, latch likewise. No strobe -> stay IDLE.
//  RD_WAIT: mem_rbusy = slv_rbusy[slot_q]; leaves to IDLE the cycle that busy is low.
//  WR_WAIT: mem_wbusy = slv_wbusy[slot_q]; same exit rule.
//  Busy is passed through combinationally in the strobe cycle via slv_sel index (no lost cycle).
//  mem_rdata = slv_rdata[slot_q] at all times after the first read; 0 after reset until first read.
//  Strobes arriving while not IDLE are protocol errors: ignored, not forwarded.
//  Reset values: mem_rdata 0, mem_rbusy 0, mem_wbusy 0, slv_rd/slv_wr 0 (strobes low),
//   bus_err 0, err_addr 0, FSM IDLE, slot_q = DEFAULT_SLOT, watchdog 0.
//  Reset asserted mid-transaction: immediate return to IDLE, busy outputs drop, no error logged.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined: counter increments each cycle in RD_WAIT/WR_WAIT with busy high,
//   clears in IDLE. At TIMEOUT_CYCLES: force mem_rbusy/mem_wbusy low that cycle, mem_rdata=ERR_RDATA
//   until next read, bus_err<=1, err_addr<=latched addr, FSM->IDLE. Counter saturates, no wrap.
//   err_clr clears bus_err; err_clr and a new timeout in same cycle: set wins.
//  BUS_TIMEOUT_EN undefined: no counter; busy held indefinitely; bus_err and err_addr tied 0.
// TESTING
//  Read slot0 addr 0x0000_0010, slv_rbusy[0] high 3 cycles, rdata 0x1234_5678 -> mem_rbusy 3 cycles, mem_rdata 0x1234_5678.
//  Write 0x0040_0004 wmask 4'b0001 -> slv_wr[1] single pulse, slv_sel 8'h02, other slv_wr 0.
//  Unmapped addr 0x00FF_0000 read -> slv_rd[DEFAULT_SLOT] pulses, data from slot 0.
//  rstrb + wmask=4'hF same cycle to 0x0041_0000 -> slv_wr[2]=1, slv_rd=0, FSM WR_WAIT.
//  BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, slv_rbusy[3] stuck -> rbusy drops at cycle 16, mem_rdata 0xDEAD_BEEF, bus_err=1, err_addr=0x0042_0000; err_clr -> 0.
//  rst_n low during RD_WAIT -> mem_rbusy 0 same cycle, bus_err 0, next read serviced normally.

Source files
------------

// File: rtl/femto_bus_fabric.sv
// femto_bus_fabric: address-decoding interconnect between a FemtoRV32 core and N peripheral slots.
// Optional watchdog abort of hung transactions when BUS_TIMEOUT_EN is defined.
module femto_bus_fabric #(
  parameter int          N_SLOTS        = 8,
  parameter logic [15:0] SLOT_BASE      = 16'h0040,
  parameter int          DEFAULT_SLOT   = 0,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            mem_addr,
  input  logic                   mem_rstrb,
  input  logic [3:0]             mem_wmask,
  output logic [31:0]            mem_rdata,
  output logic                   mem_rbusy,
  output logic                   mem_wbusy,
  output logic [N_SLOTS-1:0]     slv_sel,
  output logic [N_SLOTS-1:0]     slv_rd,
  output logic [N_SLOTS-1:0]     slv_wr,
  input  logic [32*N_SLOTS-1:0]  slv_rdata,
  input  logic [N_SLOTS-1:0]     slv_rbusy,
  input  logic [N_SLOTS-1:0]     slv_wbusy,
  input  logic                   err_clr,
  output logic                   bus_err,
  output logic [31:0]            err_addr
);
  localparam int SW = $clog2(N_SLOTS);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] slot_q, slot_d, sel_idx;
  logic [15:0] off;
  logic idle, wr_go, rd_go, wait_busy, tmo, rd_seen_q, rd_err_q;
  assign off = mem_addr[31:16] - SLOT_BASE;
  assign sel_idx = (mem_addr[31:16] == 16'h0000) ? '0 :
                   (mem_addr[31:16] >= SLOT_BASE && off < 16'(N_SLOTS-1)) ? SW'(off + 16'd1) :
                   SW'(DEFAULT_SLOT);
  assign slv_sel = {{(N_SLOTS-1){1'b0}}, 1'b1} << sel_idx;
  assign idle = state_q == IDLE;
  // A write beats a simultaneous read strobe; strobes outside IDLE are dropped.
  assign wr_go = idle & |mem_wmask;
  assign rd_go = idle & mem_rstrb & ~|mem_wmask;
  assign slv_wr = wr_go ? slv_sel : '0;
  assign slv_rd = rd_go ? slv_sel : '0;
  assign wait_busy = (state_q == RD_WAIT & slv_rbusy[slot_q]) | (state_q == WR_WAIT & slv_wbusy[slot_q]);
  assign mem_rbusy = rd_go ? slv_rbusy[sel_idx] : (state_q == RD_WAIT) & slv_rbusy[slot_q] & ~tmo;
  assign mem_wbusy = wr_go ? slv_wbusy[sel_idx] : (state_q == WR_WAIT) & slv_wbusy[slot_q] & ~tmo;
  assign mem_rdata = (tmo | rd_err_q) ? ERR_RDATA : rd_seen_q ? slv_rdata[{slot_q, 5'd0} +: 32] : '0;
  always_comb begin
    state_d = wr_go ? WR_WAIT : rd_go ? RD_WAIT : (!idle && (!wait_busy || tmo)) ? IDLE : state_q;
    slot_d  = (wr_go | rd_go) ? sel_idx : slot_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      slot_q    <= SW'(DEFAULT_SLOT);
      rd_seen_q <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      rd_seen_q <= rd_seen_q | rd_go;
      rd_err_q  <= tmo ? 1'b1 : rd_go ? 1'b0 : rd_err_q;
    end
  end
`ifdef BUS_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q;
  logic [31:0] addr_q, err_addr_q;
  logic bus_err_q;
  // Fires on the TIMEOUT_CYCLES-th consecutive busy cycle spent waiting.
  assign tmo = wait_busy & (wd_q == WW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q       <= '0;
      addr_q     <= '0;
      err_addr_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      wd_q       <= idle ? '0 : (wait_busy & ~tmo) ? wd_q + 1'b1 : wd_q;
      addr_q     <= (rd_go | wr_go) ? mem_addr : addr_q;
      err_addr_q <= tmo ? addr_q : err_addr_q;
      bus_err_q  <= tmo | (bus_err_q & ~err_clr);
    end
  end
  assign bus_err  = bus_err_q;
  assign err_addr = err_addr_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  logic unused_in;
  assign unused_in = err_clr ^ (^mem_addr[15:0]);
  assign tmo      = 1'b0;
  assign bus_err  = 1'b0;
  assign err_addr = '0;
`endif
endmodule

// File: tb/tb_femto_bus_fabric.sv
// tb_femto_bus_fabric: directed checks of decode, strobes, busy, read-data mux and reset behaviour.
module tb_femto_bus_fabric;
  logic clk = 0, rst_n = 0;
  logic [31:0] mem_addr = 0, mem_rdata, err_addr;
  logic mem_rstrb = 0, mem_rbusy, mem_wbusy, err_clr = 0, bus_err;
  logic [3:0] mem_wmask = 0;
  logic [7:0] slv_sel, slv_rd, slv_wr, slv_rbusy = 0, slv_wbusy = 0;
  logic [255:0] slv_rdata;
  int total = 0, bad = 0, n;
  femto_bus_fabric #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .slv_sel(slv_sel),
    .slv_rd(slv_rd), .slv_wr(slv_wr), .slv_rdata(slv_rdata), .slv_rbusy(slv_rbusy),
    .slv_wbusy(slv_wbusy), .err_clr(err_clr), .bus_err(bus_err), .err_addr(err_addr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    slv_rdata[31:0] = 32'h1234_5678;
    for (int k = 1; k < 8; k++) slv_rdata[32*k +: 32] = 32'hA000_0000 | k;
    #3;
    check("rst_rdata", mem_rdata, 0);
    check("rst_rbusy", {31'd0, mem_rbusy}, 0);
    check("rst_wbusy", {31'd0, mem_wbusy}, 0);
    check("rst_strobes", {slv_rd, slv_wr}, 0);
    check("rst_err", {31'd0, bus_err}, 0);
    check("rst_err_addr", err_addr, 0);
    cyc(); rst_n = 1;
    cyc();
    mem_addr = 32'h0000_0010; mem_rstrb = 1; slv_rbusy = 8'h01;
    #1;
    check("rd0_sel", {24'd0, slv_sel}, 8'h01);
    check("rd0_strobe", {24'd0, slv_rd}, 8'h01);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin cyc(); mem_rstrb = 0; slv_rbusy[0] = (i < 3); #1; end
      if (!mem_rbusy) break;
      n++;
    end
    check("rd0_busy_cycles", n, 3);
    check("rd0_rdata", mem_rdata, 32'h1234_5678);
    cyc();
    mem_addr = 32'h0040_0004; mem_wmask = 4'b0001;
    #1;
    check("wr1_sel", {24'd0, slv_sel}, 8'h02);
    check("wr1_strobe", {24'd0, slv_wr}, 8'h02);
    check("wr1_no_rd", {24'd0, slv_rd}, 0);
    cyc(); mem_wmask = 0; #1;
    check("wr1_single_pulse", {24'd0, slv_wr}, 0);
    cyc();
    mem_addr = 32'h00FF_0000; mem_rstrb = 1;
    #1;
    check("unmapped_rd", {24'd0, slv_rd}, 8'h01);
    cyc(); mem_rstrb = 0; #1;
    check("unmapped_rdata", mem_rdata, 32'h1234_5678);
    cyc();
    mem_addr = 32'h0041_0000; mem_rstrb = 1; mem_wmask = 4'hF; slv_wbusy = 8'h04;
    #1;
    check("both_wr", {24'd0, slv_wr}, 8'h04);
    check("both_rd", {24'd0, slv_rd}, 0);
    check("both_wbusy", {31'd0, mem_wbusy}, 1);
    check("both_rbusy", {31'd0, mem_rbusy}, 0);
    cyc(); mem_wmask = 0; mem_addr = 32'h0000_0010; #1;
    check("wr_wait_busy", {31'd0, mem_wbusy}, 1);
    check("ignored_rd", {24'd0, slv_rd}, 0);
    cyc(); mem_rstrb = 0; slv_wbusy = 0; #1;
    check("wr_wait_done", {31'd0, mem_wbusy}, 0);
    mem_addr = 32'h0046_1234; #1; check("dec_last", {24'd0, slv_sel}, 8'h80);
    mem_addr = 32'h0047_0000; #1; check("dec_above", {24'd0, slv_sel}, 8'h01);
    mem_addr = 32'h003F_FFFF; #1; check("dec_below", {24'd0, slv_sel}, 8'h01);
    mem_addr = 32'h0042_0000; #1; check("dec_slot3", {24'd0, slv_sel}, 8'h08);
    cyc();
    mem_rstrb = 1; slv_rbusy = 8'h08;
`ifdef BUS_TIMEOUT_EN
    #1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin cyc(); mem_rstrb = 0; #1; end
      if (!mem_rbusy) break;
      n++;
    end
    check("tmo_busy_cycles", n, 16);
    check("tmo_rdata", mem_rdata, 32'hDEAD_BEEF);
    cyc(); #1;
    check("tmo_err", {31'd0, bus_err}, 1);
    check("tmo_err_addr", err_addr, 32'h0042_0000);
    check("tmo_rdata_hold", mem_rdata, 32'hDEAD_BEEF);
    err_clr = 1; cyc(); err_clr = 0; #1;
    check("tmo_err_clr", {31'd0, bus_err}, 0);
`else
    for (int i = 0; i < 20; i++) begin cyc(); mem_rstrb = 0; end
    #1;
    check("stuck_busy_held", {31'd0, mem_rbusy}, 1);
    check("stuck_no_err", {31'd0, bus_err}, 0);
`endif
    slv_rbusy = 0;
    cyc(); cyc();
    mem_rstrb = 1; slv_rbusy = 8'h08;
    cyc(); mem_rstrb = 0; #1;
    check("pre_rst_busy", {31'd0, mem_rbusy}, 1);
    rst_n = 0; #1;
    check("rst_mid_busy", {31'd0, mem_rbusy}, 0);
    check("rst_mid_err", {31'd0, bus_err}, 0);
    check("rst_mid_rdata", mem_rdata, 0);
    cyc(); rst_n = 1; slv_rbusy = 0;
    cyc();
    mem_addr = 32'h0041_0000; mem_rstrb = 1;
    #1;
    check("post_rst_rd", {24'd0, slv_rd}, 8'h04);
    cyc(); mem_rstrb = 0; #1;
    check("post_rst_rbusy", {31'd0, mem_rbusy}, 0);
    check("post_rst_rdata", mem_rdata, 32'hA000_0002);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
